// File: rtl/xoodyak_hash_stream.sv
// xoodyak_hash_stream: Xoodyak-style hash, byte-stream absorb, 16-byte-block squeeze, Xoodoo unrolled ROUNDS_PER_CYCLE rounds/clock.
// Define XHASH_ABORT_EN to add the abort input (returns to IDLE without a done pulse).
module xoodyak_hash_stream #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int DIGEST_BYTES = 32,
   parameter int LEN_W = 12
) (
   input logic clk,
   input logic reset,
`ifdef XHASH_ABORT_EN
   input logic abort,
`endif
   input logic start,
   input logic [LEN_W-1:0] msg_len,
   input logic [7:0] msg_data,
   input logic msg_valid,
   output logic msg_ready,
   output logic [7:0] hash_data,
   output logic hash_valid,
   input logic hash_ready,
   output logic hash_last,
   output logic busy,
   output logic done
);
   typedef enum logic [2:0] {IDLE, ABSORB, DOWN, PERM, OUT, SQ_DOWN} fsm_t;
   localparam logic [143:0] RCS = {12'h012, 12'h1A0, 12'h0F0, 12'h380, 12'h02C, 12'h060,
                                   12'h014, 12'h120, 12'h0D0, 12'h3C0, 12'h038, 12'h058};
   fsm_t fsm;
   logic [383:0] st, pst;
   logic [LEN_W-1:0] rem;
   logic first, kill;
   logic [4:0] blk_cnt;
   logic [3:0] out_idx, rnd_cnt;
   logic [7:0] dig_cnt;
   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction
   function automatic logic [383:0] xround(input logic [383:0] s, input logic [3:0] i);
      logic [31:0] a [12];
      logic [31:0] b [12];
      logic [31:0] p [4];
      logic [31:0] e [4];
      logic [383:0] o;
      for (int w = 0; w < 12; w++) a[w] = s[32*w +: 32];
      for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
      for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      for (int w = 0; w < 12; w++) a[w] = a[w] ^ e[w%4];
      b = a;
      for (int x = 0; x < 4; x++) begin
         a[4+x] = b[4+(x+3)%4];
         a[8+x] = rol(b[8+x], 11);
      end
      a[0] = a[0] ^ {20'd0, RCS[12*i +: 12]};
      b = a;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++)
            a[x+4*y] = b[x+4*y] ^ (~b[x+4*((y+1)%3)] & b[x+4*((y+2)%3)]);
      b = a;
      for (int x = 0; x < 4; x++) begin
         a[4+x] = rol(b[4+x], 1);
         a[8+x] = rol(b[8+(x+2)%4], 8);
      end
      for (int w = 0; w < 12; w++) o[32*w +: 32] = a[w];
      return o;
   endfunction
`ifdef XHASH_ABORT_EN
   assign kill = reset || (abort && fsm != IDLE);
`else
   assign kill = reset;
`endif
   always_comb begin
      pst = st;
      for (int r = 0; r < ROUNDS_PER_CYCLE; r++) pst = xround(pst, rnd_cnt + 4'(r));
   end
   assign msg_ready = fsm == ABSORB;
   assign hash_valid = fsm == OUT;
   assign hash_last = hash_valid && dig_cnt == 8'(DIGEST_BYTES - 1);
   assign hash_data = hash_valid ? st[8*out_idx +: 8] : 8'h00;
   assign busy = fsm != IDLE;
   always_ff @(posedge clk) begin
      if (kill) begin
         fsm <= IDLE;
         st <= '0;
         rem <= '0;
         first <= 1'b0;
         blk_cnt <= '0;
         out_idx <= '0;
         dig_cnt <= '0;
         rnd_cnt <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: if (start) begin
               st <= '0;
               rem <= msg_len;
               first <= 1'b1;
               blk_cnt <= '0;
               out_idx <= '0;
               dig_cnt <= '0;
               rnd_cnt <= '0;
               fsm <= msg_len != '0 ? ABSORB : DOWN;
            end
            ABSORB: if (msg_valid) begin
               st[8*blk_cnt +: 8] <= st[8*blk_cnt +: 8] ^ msg_data;
               blk_cnt <= blk_cnt + 5'd1;
               rem <= rem - LEN_W'(1);
               if (blk_cnt == 5'd15 || rem == LEN_W'(1)) fsm <= DOWN;
            end
            DOWN: begin
               st[8*blk_cnt +: 8] <= st[8*blk_cnt +: 8] ^ 8'h01;
               if (first) st[383:376] <= st[383:376] ^ 8'h01;
               first <= 1'b0;
               blk_cnt <= '0;
               fsm <= PERM;
            end
            PERM: begin
               st <= pst;
               // rem is zero once absorb is over, so squeeze permutations also land in OUT
               if (rnd_cnt == 4'(12 - ROUNDS_PER_CYCLE)) begin
                  rnd_cnt <= '0;
                  fsm <= rem != '0 ? ABSORB : OUT;
               end else rnd_cnt <= rnd_cnt + 4'(ROUNDS_PER_CYCLE);
            end
            OUT: if (hash_ready) begin
               out_idx <= out_idx + 4'd1;
               dig_cnt <= dig_cnt + 8'd1;
               if (dig_cnt == 8'(DIGEST_BYTES - 1)) begin
                  fsm <= IDLE;
                  done <= 1'b1;
               end else if (out_idx == 4'd15) fsm <= SQ_DOWN;
            end
            SQ_DOWN: begin
               st[7:0] <= st[7:0] ^ 8'h01;
               fsm <= PERM;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xoodyak_hash_stream.sv
// tb_xoodyak_hash_stream: scoreboard bench; a lane-plane Xoodoo model predicts every digest byte.
module tb_xoodyak_hash_stream;
   localparam int R = 1, D = 40, LW = 12, PL = 12 / R;
   logic clk = 0, reset = 1, start = 0, msg_valid = 0, hash_ready = 1;
   logic [LW-1:0] msg_len = '0;
   logic [7:0] msg_data = '0;
   logic msg_ready, hash_valid, hash_last, busy, done;
   logic [7:0] hash_data;
`ifdef XHASH_ABORT_EN
   logic abort = 0;
`endif
   int checks = 0, errors = 0, cyc = 0, last_cyc = -10;
   bit stall = 0, held = 0;
   logic [7:0] held_d;
   logic [8:0] exp_b;
   logic [8:0] sb [$];
   bit [7:0] msg [64];
   bit [31:0] ln [3][4];
   bit [11:0] rc_tab [12] = '{12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
                              12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012};

   xoodyak_hash_stream #(.ROUNDS_PER_CYCLE(R), .DIGEST_BYTES(D), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset),
`ifdef XHASH_ABORT_EN
      .abort(abort),
`endif
      .start(start), .msg_len(msg_len), .msg_data(msg_data), .msg_valid(msg_valid),
      .msg_ready(msg_ready), .hash_data(hash_data), .hash_valid(hash_valid),
      .hash_ready(hash_ready), .hash_last(hash_last), .busy(busy), .done(done));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1 hash_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (reset || !hash_valid) held = 0;
      else begin
         if (held) begin
            checks++;
            if (hash_data !== held_d) begin
               errors++;
               $display("FAIL stall_stable: hash_data=%h required %h", hash_data, held_d);
            end
         end
         if (hash_ready) begin
            held = 0;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_byte: got last=%b data=%h, required no output", hash_last, hash_data);
            end else begin
               exp_b = sb.pop_front();
               if ({hash_last, hash_data} !== exp_b) begin
                  errors++;
                  $display("FAIL digest_byte %0d: got last=%b data=%h, required last=%b data=%h",
                           D - 1 - sb.size(), hash_last, hash_data, exp_b[8], exp_b[7:0]);
               end
               if (exp_b[8]) last_cyc = cyc;
            end
         end else begin
            held = 1;
            held_d = hash_data;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "watchdog");
   end

   function automatic bit [31:0] rl(input bit [31:0] v, input int n);
      bit [63:0] t;
      t = {v, v};
      return t[63-n -: 32];
   endfunction

   task automatic xb(input int k, input bit [7:0] v);
      ln[k/16][(k%16)/4][8*(k%4) +: 8] ^= v;
   endtask

   function automatic bit [7:0] gb(input int k);
      return ln[k/16][(k%16)/4][8*(k%4) +: 8];
   endfunction

   task automatic model_perm();
      bit [31:0] p [4];
      bit [31:0] e [4];
      bit [31:0] b [3][4];
      for (int i = 0; i < 12; i++) begin
         for (int x = 0; x < 4; x++) p[x] = ln[0][x] ^ ln[1][x] ^ ln[2][x];
         for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
         for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) ln[y][x] ^= e[x];
         b = ln;
         for (int x = 0; x < 4; x++) begin
            ln[1][x] = b[1][(x+3)%4];
            ln[2][x] = rl(b[2][x], 11);
         end
         ln[0][0] ^= {20'd0, rc_tab[i]};
         b = ln;
         for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++)
            ln[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
         b = ln;
         for (int x = 0; x < 4; x++) begin
            ln[1][x] = rl(b[1][x], 1);
            ln[2][x] = rl(b[2][(x+2)%4], 8);
         end
      end
   endtask

   task automatic model_hash(input int len);
      int rem, pos, n;
      bit first;
      ln = '{default: '0};
      rem = len;
      pos = 0;
      first = 1;
      do begin
         n = rem < 16 ? rem : 16;
         for (int j = 0; j < n; j++) xb(j, msg[pos+j]);
         pos += n;
         rem -= n;
         xb(n, 8'h01);
         if (first) xb(47, 8'h01);
         first = 0;
         model_perm();
      end while (rem > 0);
      for (int k = 0; k < D; k++) begin
         if (k > 0 && k % 16 == 0) begin
            xb(0, 8'h01);
            model_perm();
         end
         sb.push_back({k == D - 1, gb(k % 16)});
      end
   endtask

   task automatic do_start(input int len);
      @(posedge clk);
      #1 start = 1;
      msg_len = LW'(len);
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic send_msg(input int n, input bit gaps, output int got);
      bit took;
      int guard = 0;
      got = 0;
      while (got < n && guard < 1000) begin
         msg_data = msg[got];
         msg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         took = msg_valid && msg_ready;
         @(posedge clk);
         #1 if (took) got++;
         guard++;
      end
      msg_valid = 0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 5000);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
      end else begin
         checks++;
         if (cyc !== last_cyc + 1) begin
            errors++;
            $display("FAIL %s_done_timing: done at cycle %0d, required %0d", name, cyc, last_cyc + 1);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d digest bytes never seen, required 0", name, sb.size());
      end
      sb.delete();
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_done_pulse: done,busy=%b required 00", name, {done, busy});
      end
   endtask

   task automatic check_cleared(input string name);
      checks++;
      if ({msg_ready, hash_valid, hash_last, busy, done, hash_data} !== 13'd0) begin
         errors++;
         $display("FAIL %s: outputs=%h required 0", name,
                  {msg_ready, hash_valid, hash_last, busy, done, hash_data});
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 reset = 1;
      @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset_held");
      @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      check_cleared("reset_idle");
   endtask

   task automatic test_empty();
      int n = 0;
      model_hash(0);
      do_start(0);
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            checks++;
            if ({busy, msg_ready} !== 2'b10) begin
               errors++;
               $display("FAIL empty_busy: busy,msg_ready=%b required 10", {busy, msg_ready});
            end
         end
      end while (!hash_valid && n < 100);
      checks++;
      if (n != PL + 2) begin
         errors++;
         $display("FAIL empty_latency: hash_valid after %0d cycles, required %0d", n, PL + 2);
      end
      wait_done("empty");
   endtask

   task automatic test_block16();
      int got;
      for (int i = 0; i < 16; i++) msg[i] = 8'(i);
      model_hash(16);
      do_start(16);
      send_msg(16, 0, got);
      checks++;
      if (got != 16) begin
         errors++;
         $display("FAIL block16_count: %0d handshakes, required 16", got);
      end
      @(negedge clk);
      checks++;
      if (msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL block16_ready: msg_ready=%b after 16 bytes, required 0", msg_ready);
      end
      wait_done("block16");
   endtask

   task automatic test_gaps_stalls();
      int got;
      for (int i = 0; i < 33; i++) msg[i] = 8'($urandom);
      model_hash(33);
      stall = 1;
      do_start(33);
      @(posedge clk);
      #1 start = 1;
      msg_len = LW'(5);
      @(posedge clk);
      #1 start = 0;
      send_msg(33, 1, got);
      checks++;
      if (got != 33) begin
         errors++;
         $display("FAIL gaps_count: %0d handshakes, required 33", got);
      end
      wait_done("gaps");
      stall = 0;
   endtask

   task automatic test_back_to_back();
      int got;
      for (int i = 0; i < 5; i++) msg[i] = 8'(8'hA0 + i);
      model_hash(5);
      stall = 1;
      do_start(5);
      send_msg(5, 0, got);
      wait_done("squeeze5");
      stall = 0;
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      model_hash(32);
      do_start(32);
      send_msg(32, 0, got);
      checks++;
      if (got != 32) begin
         errors++;
         $display("FAIL len32_count: %0d handshakes, required 32", got);
      end
      wait_done("len32");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_start(0);
      repeat (5) @(negedge clk);
      pulse_reset();
      check_cleared("reset_mid_perm");
      model_hash(0);
      do_start(0);
      do begin
         @(negedge clk);
         n++;
      end while (!hash_valid && n < 100);
      repeat (3) @(negedge clk);
      pulse_reset();
      check_cleared("reset_mid_out");
      sb.delete();
      test_empty();
   endtask

`ifdef XHASH_ABORT_EN
   task automatic test_abort();
      int got;
      bit seen = 0;
      for (int i = 0; i < 20; i++) msg[i] = 8'($urandom);
      do_start(20);
      send_msg(7, 0, got);
      @(posedge clk);
      #1 abort = 1;
      @(posedge clk);
      #1 abort = 0;
      @(negedge clk);
      check_cleared("abort_idle");
      repeat (4) begin
         @(negedge clk);
         seen |= done;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_done: done=1 after abort, required 0");
      end
      model_hash(20);
      do_start(20);
      send_msg(20, 0, got);
      wait_done("after_abort");
   endtask
`endif

   initial begin
      test_reset();
      test_empty();
      test_block16();
      test_gaps_stalls();
      test_back_to_back();
      test_reset_mid();
`ifdef XHASH_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
